alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
- Upstream control stage for the 1 kHz buzzer tone generator; drives that block's `enable` input.
- Runs a programmable seconds countdown from the 12 MHz board clock.
- On expiry, produces a gated on/off beep cadence until stopped, snoozed or timed out.
- Also exposes remaining time and ringing status for display logic.

Parameters:
- MS_DIV, 12000, clock cycles per millisecond tick (12 MHz / 1 kHz).
- MS_PER_S, 1000, millisecond ticks per second tick (override small for simulation).
- BEEP_ON_MS, 250, ENABLE high time per cadence period, in ms (≥1).
- BEEP_OFF_MS, 250, ENABLE low time per cadence period, in ms (≥1).
- RING_TIMEOUT_S, 60, seconds of ringing before automatic return to idle (≥1).
- SNOOZE_S, 300, snooze countdown length in seconds (≥1).

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST_N  in  1  synchronous active-low reset.
- LOAD_SEC  in  16  countdown length in seconds, sampled on START.
- START  in  1  one-cycle start/restart strobe.
- STOP  in  1  one-cycle acknowledge/cancel strobe.
- SNOOZE  in  1  one-cycle snooze strobe.
- ENABLE  out  1  gate to buzzer tone generator, registered.
- RINGING  out  1  high while in RINGING state, registered.
- REMAIN  out  16  seconds remaining in COUNTING/SNOOZED, else 0.
- TIMED_OUT  out  1  one-cycle pulse when ringing ends by timeout.

Behaviour:
- Interface: one clock, CLK; reset RST_N is synchronous and active-low.
- Reset (RST_N low at a CLK edge): state IDLE. ENABLE=0, RINGING=0, REMAIN=0, TIMED_OUT=0. All prescalers and counters are 0.
- Timebase:
  - ms_tick is a one-cycle pulse when the cycle prescaler equals MS_DIV-1; the prescaler then wraps to 0.
  - sec_tick is a pulse when ms_tick fires and the ms counter equals MS_PER_S-1; the ms counter then wraps to 0.
  - Both counters clear on any state entry, so the first second after entry is exactly MS_DIV*MS_PER_S cycles.
- Input priority when strobes coincide: STOP > SNOOZE > START.
- States: IDLE, COUNTING, RINGING, SNOOZED.
- IDLE:
  - START with LOAD_SEC≠0 → COUNTING, REMAIN=LOAD_SEC.
  - START with LOAD_SEC=0 → RINGING at the next edge.
- COUNTING:
  - Each sec_tick decrements REMAIN.
  - When the decrement makes REMAIN 0, go to RINGING on that same edge.
  - START restarts the countdown with the new LOAD_SEC (0 → RINGING).
  - SNOOZE is ignored.
- RINGING:
  - ENABLE and RINGING are both set on the entry edge.
  - Cadence counter in ms: ENABLE=1 for BEEP_ON_MS ms, then 0 for BEEP_OFF_MS ms, repeating.
  - Ring timer counts sec_ticks. At RING_TIMEOUT_S → IDLE, with TIMED_OUT high for that one cycle.
  - SNOOZE → SNOOZED, REMAIN=SNOOZE_S, ENABLE=0.
  - START → treated as restart (COUNTING with LOAD_SEC).
- SNOOZED:
  - Counts down like COUNTING; on reaching 0, returns to RINGING.
  - Cadence counter and ring timer restart on that return.
  - START restarts as in COUNTING.
- STOP in any state → IDLE next edge, with ENABLE=0 and REMAIN=0.
- ENABLE is low in every state except RINGING. ENABLE never glitches: it is a flop output.
- REMAIN has no wrap: decrement is applied only when REMAIN>0.
- Reset during any state aborts immediately to the reset values.

Optional Feature:
- Macro ALARM_SEQ_SNOOZE_EN.
- Defined: SNOOZED state and SNOOZE input are active as above.
- Undefined:
  - SNOOZED state and the SNOOZE_S logic are not built.
  - The SNOOZE port remains but is ignored.
  - In RINGING, only STOP, START or the timeout leave the state.

Test Plan:
Bench parameters for all scenarios: MS_DIV=4, MS_PER_S=5 (1 s = 20 cycles), BEEP_ON_MS=2, BEEP_OFF_MS=3, RING_TIMEOUT_S=2, SNOOZE_S=1.
- Reset: hold RST_N=0 for 3 edges with random strobes → all outputs 0, state IDLE; REMAIN=0 after release.
- Countdown: START with LOAD_SEC=3 at edge E0 → REMAIN=3, 2, 1 at E0, E0+20, E0+40. ENABLE and RINGING rise at E0+60.
- Cadence and timeout: continue from the countdown scenario → ENABLE high for cycles 0-7 and 20-27 after ring entry, low otherwise. At entry+40: TIMED_OUT pulses for 1 cycle, then IDLE with ENABLE=0.
- STOP during ring: STOP at ring entry+3 → ENABLE=0 at +4 and stays 0. STOP asserted together with START → IDLE wins.
- Zero load and restart: START with LOAD_SEC=0 → RINGING at the next edge. START with LOAD_SEC=2 during COUNTING at REMAIN=1 → REMAIN=2 and a full 40-cycle countdown.
- Snooze (macro defined): SNOOZE at ring entry+5 → ENABLE=0 and REMAIN=1; RINGING again 20 cycles later with cadence restarted. With the macro undefined, the same stimulus leaves ENABLE cadence unaffected.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm countdown and beep-cadence sequencer feeding the buzzer tone generator's enable.
// Optional snooze support is built only when ALARM_SEQ_SNOOZE_EN is defined.
module alarm_sequencer #(
  parameter int MS_DIV         = 12000,
  parameter int MS_PER_S       = 1000,
  parameter int BEEP_ON_MS     = 250,
  parameter int BEEP_OFF_MS    = 250,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] LOAD_SEC,
  input  logic        START,
  input  logic        STOP,
  input  logic        SNOOZE,
  output logic        ENABLE,
  output logic        RINGING,
  output logic [15:0] REMAIN,
  output logic        TIMED_OUT
);

  localparam int PW = $clog2(MS_DIV + 1);
  localparam int MW = $clog2(MS_PER_S + 1);
  localparam int CW = $clog2(BEEP_ON_MS + BEEP_OFF_MS + 1);
  localparam int RW = $clog2(RING_TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTING,
`ifdef ALARM_SEQ_SNOOZE_EN
    S_SNOOZED,
`endif
    S_RINGING
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms_cnt;
  logic [CW-1:0] cad, cad_n;
  logic [RW-1:0] ring_sec;
  logic          ms_tick, sec_tick;
  logic          start_go, snooze_go, timeout, restart;
  logic          enable_d;
  logic [15:0]   remain_d;

  assign ms_tick  = (pre == PW'(MS_DIV - 1));
  assign sec_tick = ms_tick && (ms_cnt == MW'(MS_PER_S - 1));
  // Any state entry or countdown reload restarts the timebase, cadence and ring timer.
  assign restart  = (state_n != state) || start_go || snooze_go;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_go  = 1'b0;
    snooze_go = 1'b0;
    timeout   = 1'b0;
    if (STOP) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) start_go = 1'b1;
        end
        S_COUNTING: begin
          if (START) start_go = 1'b1;
          else if (sec_tick && REMAIN == 16'd1) state_n = S_RINGING;
        end
`ifdef ALARM_SEQ_SNOOZE_EN
        S_SNOOZED: begin
          if (START) start_go = 1'b1;
          else if (sec_tick && REMAIN == 16'd1) state_n = S_RINGING;
        end
`endif
        S_RINGING: begin
`ifdef ALARM_SEQ_SNOOZE_EN
          if (SNOOZE) begin
            snooze_go = 1'b1;
            state_n   = S_SNOOZED;
          end else
`endif
          if (START) begin
            start_go = 1'b1;
          end else if (sec_tick && ring_sec == RW'(RING_TIMEOUT_S - 1)) begin
            timeout = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
      if (start_go) state_n = (LOAD_SEC != 16'd0) ? S_COUNTING : S_RINGING;
    end
  end

  always_comb begin
    cad_n    = cad;
    remain_d = '0;
    enable_d = 1'b0;
    if (ms_tick) cad_n = (cad == CW'(BEEP_ON_MS + BEEP_OFF_MS - 1)) ? '0 : cad + 1'b1;
    if (restart) cad_n = '0;
    case (state_n)
      S_COUNTING: begin
        if (start_go)                        remain_d = LOAD_SEC;
        else if (sec_tick && REMAIN != 16'd0) remain_d = REMAIN - 16'd1;
        else                                  remain_d = REMAIN;
      end
`ifdef ALARM_SEQ_SNOOZE_EN
      S_SNOOZED: begin
        if (snooze_go)                        remain_d = 16'(SNOOZE_S);
        else if (sec_tick && REMAIN != 16'd0) remain_d = REMAIN - 16'd1;
        else                                  remain_d = REMAIN;
      end
`endif
      S_RINGING: enable_d = (cad_n < CW'(BEEP_ON_MS));
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pre       <= '0;
      ms_cnt    <= '0;
      ring_sec  <= '0;
      cad       <= '0;
      ENABLE    <= 1'b0;
      RINGING   <= 1'b0;
      REMAIN    <= '0;
      TIMED_OUT <= 1'b0;
    end else begin
      if (restart || state == S_IDLE) begin
        pre      <= '0;
        ms_cnt   <= '0;
        ring_sec <= '0;
      end else begin
        pre <= ms_tick ? '0 : pre + 1'b1;
        if (ms_tick) ms_cnt <= (ms_cnt == MW'(MS_PER_S - 1)) ? '0 : ms_cnt + 1'b1;
        if (sec_tick && state == S_RINGING) ring_sec <= ring_sec + 1'b1;
      end
      cad       <= cad_n;
      ENABLE    <= enable_d;
      RINGING   <= (state_n == S_RINGING);
      REMAIN    <= remain_d;
      TIMED_OUT <= timeout;
    end
  end

`ifndef ALARM_SEQ_SNOOZE_EN
  logic unused_snooze;
  assign unused_snooze = SNOOZE ^ (SNOOZE_S == 0);
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer with a shortened timebase (1 s = 20 cycles).
module tb_alarm_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] LOAD_SEC = '0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        SNOOZE = 1'b0;
  logic        ENABLE, RINGING, TIMED_OUT;
  logic [15:0] REMAIN;

  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  alarm_sequencer #(
    .MS_DIV(4), .MS_PER_S(5), .BEEP_ON_MS(2), .BEEP_OFF_MS(3),
    .RING_TIMEOUT_S(2), .SNOOZE_S(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD_SEC(LOAD_SEC), .START(START), .STOP(STOP),
    .SNOOZE(SNOOZE), .ENABLE(ENABLE), .RINGING(RINGING), .REMAIN(REMAIN),
    .TIMED_OUT(TIMED_OUT)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive strobes for exactly one sampling edge, then return 1 time unit after that edge.
  task automatic applyStimulus(input logic start, input logic stop, input logic snooze, input logic [15:0] load);
    START = start; STOP = stop; SNOOZE = snooze; LOAD_SEC = load;
    @(posedge CLK);
    #1;
    START = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_en"}, ENABLE, 0);
    checkOutput({tag, "_ring"}, RINGING, 0);
    checkOutput({tag, "_remain"}, REMAIN, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic exp_en;

    // Reset held with random strobes
    for (int i = 0; i < 3; i++) begin
      START = 1'($urandom); STOP = 1'($urandom); SNOOZE = 1'($urandom);
      LOAD_SEC = 16'($urandom);
      @(posedge CLK);
      #1;
      checkIdle($sformatf("rst%0d", i));
      checkOutput($sformatf("rst%0d_to", i), TIMED_OUT, 0);
    end
    START = 1'b0; STOP = 1'b0; SNOOZE = 1'b0; LOAD_SEC = '0;
    RST_N = 1'b1;
    step(1);
    checkIdle("post_rst");

    // Countdown from 3
    applyStimulus(1, 0, 0, 16'd3);
    checkOutput("cnt_e0", REMAIN, 3);
    checkOutput("cnt_e0_ring", RINGING, 0);
    step(19); checkOutput("cnt_e19", REMAIN, 3);
    step(1);  checkOutput("cnt_e20", REMAIN, 2);
    step(19); checkOutput("cnt_e39", REMAIN, 2);
    step(1);  checkOutput("cnt_e40", REMAIN, 1);
    step(19); checkOutput("cnt_e59", REMAIN, 1);
    checkOutput("cnt_e59_ring", RINGING, 0);
    checkOutput("cnt_e59_en", ENABLE, 0);
    step(1);
    checkOutput("ring_entry", RINGING, 1);
    checkOutput("ring_entry_remain", REMAIN, 0);

    // Cadence 8 on / 12 off and timeout after 40 cycles
    for (int k = 0; k < 40; k++) begin
      exp_en = (k < 8 || (k >= 20 && k < 28)) ? 1'b1 : 1'b0;
      checkOutput($sformatf("cad_en%0d", k), ENABLE, exp_en);
      checkOutput($sformatf("cad_to%0d", k), TIMED_OUT, 0);
      step(1);
    end
    checkOutput("timeout_pulse", TIMED_OUT, 1);
    checkIdle("timeout");
    step(1);
    checkOutput("timeout_clear", TIMED_OUT, 0);
    checkIdle("after_timeout");

    // STOP during ring
    applyStimulus(1, 0, 0, 16'd0);
    checkOutput("zero_load_ring", RINGING, 1);
    checkOutput("zero_load_en", ENABLE, 1);
    step(3);
    checkOutput("stop_pre_en", ENABLE, 1);
    applyStimulus(0, 1, 0, 16'd0);
    checkIdle("stop_ring");
    step(25);
    checkIdle("stop_ring_late");

    // STOP together with START
    applyStimulus(1, 1, 0, 16'd5);
    checkIdle("stop_start_idle");
    applyStimulus(1, 0, 0, 16'd4);
    checkOutput("cnt4", REMAIN, 4);
    applyStimulus(1, 1, 0, 16'd7);
    checkIdle("stop_start_cnt");

    // Restart mid-countdown
    applyStimulus(1, 0, 0, 16'd3);
    step(40);
    checkOutput("rs_remain1", REMAIN, 1);
    applyStimulus(1, 0, 0, 16'd2);
    checkOutput("rs_load", REMAIN, 2);
    step(19); checkOutput("rs_e19", REMAIN, 2);
    step(1);  checkOutput("rs_e20", REMAIN, 1);
    step(19); checkOutput("rs_e39", REMAIN, 1);
    checkOutput("rs_e39_ring", RINGING, 0);
    step(1);
    checkOutput("rs_e40_ring", RINGING, 1);
    checkOutput("rs_e40_en", ENABLE, 1);
    applyStimulus(0, 1, 0, 16'd0);
    checkIdle("rs_stop");

    // SNOOZE ignored while counting
    applyStimulus(1, 0, 0, 16'd2);
    step(2);
    applyStimulus(0, 0, 1, 16'd0);
    checkOutput("cnt_snooze_remain", REMAIN, 2);
    step(17);
    checkOutput("cnt_snooze_e20", REMAIN, 1);
    applyStimulus(0, 1, 0, 16'd0);

    // Snooze during ring
    applyStimulus(1, 0, 0, 16'd0);
    step(5);
    applyStimulus(0, 0, 1, 16'd0);
`ifdef ALARM_SEQ_SNOOZE_EN
    checkOutput("snz_en", ENABLE, 0);
    checkOutput("snz_ring", RINGING, 0);
    checkOutput("snz_remain", REMAIN, 1);
    step(19);
    checkOutput("snz_e19_ring", RINGING, 0);
    checkOutput("snz_e19_remain", REMAIN, 1);
    step(1);
    checkOutput("snz_rering", RINGING, 1);
    checkOutput("snz_rering_en", ENABLE, 1);
    checkOutput("snz_rering_remain", REMAIN, 0);
    step(7);
    checkOutput("snz_cad7", ENABLE, 1);
    step(1);
    checkOutput("snz_cad8", ENABLE, 0);
`else
    checkOutput("nosnz_en", ENABLE, 1);
    checkOutput("nosnz_ring", RINGING, 1);
    checkOutput("nosnz_remain", REMAIN, 0);
    step(2);
    checkOutput("nosnz_cad8", ENABLE, 0);
    step(12);
    checkOutput("nosnz_cad20", ENABLE, 1);
`endif
    applyStimulus(0, 1, 0, 16'd0);
    checkIdle("snz_stop");

    // Reset while ringing
    applyStimulus(1, 0, 0, 16'd0);
    step(2);
    RST_N = 1'b0;
    step(1);
    checkIdle("rst_ring");
    RST_N = 1'b1;
    step(3);
    checkIdle("rst_ring_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
